// File: rtl/fifo_wr_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_packer_if
// Description : Bundles the narrow input stream (s_*) and the async-FIFO write
//               port (winc/wdata/wfull) seen by fifo_wr_packer.
//               slave  - the packer's view (consumes beats, drives the FIFO)
//               master - the environment's view (upstream source + FIFO)
// Signals     : s_valid/s_ready/s_data/s_last - input beat handshake
//               winc/wdata                    - FIFO write strobe and data
//               wfull                         - FIFO full flag
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_wr_packer_if #(
    parameter int WIDTH = 8,
    parameter int IN_W  = 2
);
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic             s_last;
    logic             winc;
    logic [WIDTH-1:0] wdata;
    logic             wfull;

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  wfull,
        output s_ready,
        output winc,
        output wdata
    );

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output wfull,
        input  s_ready,
        input  winc,
        input  wdata
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_packer
// Description : Write-side packer in the wclk domain. Packs RATIO=WIDTH/IN_W
//               narrow beats into one FIFO word (little-endian lanes), pads
//               unfilled lanes with PAD_VAL when a frame ends early, and drives
//               the async FIFO write port while honouring wfull.
// Ports       : wclk       - write clock
//               wrstn      - asynchronous active-low reset
//               bus        - stream input + FIFO write port (slave modport)
//               o_wr_words - wrapping count of words written to the FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_packer #(
    parameter int              WIDTH   = 8,
    parameter int              IN_W    = 2,
    parameter logic [IN_W-1:0] PAD_VAL = '0,
    parameter int              CNT_W   = 16
) (
    input  wire logic             wclk,
    input  wire logic             wrstn,
    fifo_wr_packer_if.slave       bus,
    output      logic [CNT_W-1:0] o_wr_words
);

    localparam int c_RATIO = WIDTH / IN_W;
    localparam int c_IDX_W = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_RATIO - 1);

    logic [c_IDX_W-1:0] r_idx;       // next lane to fill
    logic [WIDTH-1:0]   r_acc;       // partially packed word
    logic               r_out_vld;   // output word held, waiting for winc
    logic [WIDTH-1:0]   r_wdata;
    logic [CNT_W-1:0]   r_wr_words;

    logic               w_ready;
    logic               w_winc;
    logic               w_accept;
    logic               w_complete;
    logic [WIDTH-1:0]   w_merged;    // acc + current beat + padding above it
    logic [WIDTH-1:0]   w_acc_upd;   // acc + current beat only

    // Conservative handshake: a stalled held word blocks every beat, even one
    // that would only fill a lane, so ready never depends on s_valid/s_last.
    assign w_ready    = ~r_out_vld | ~bus.wfull;
    assign w_winc     = r_out_vld & ~bus.wfull;
    assign w_accept   = bus.s_valid & w_ready;
    assign w_complete = w_accept & ((r_idx == c_LAST_IDX) | bus.s_last);

    always_comb begin
        w_merged  = '0;
        w_acc_upd = r_acc;
        for (int k = 0; k < c_RATIO; k++) begin
            if (c_IDX_W'(k) < r_idx) begin
                w_merged[k*IN_W +: IN_W] = r_acc[k*IN_W +: IN_W];
            end else if (c_IDX_W'(k) == r_idx) begin
                w_merged[k*IN_W +: IN_W]  = bus.s_data;
                w_acc_upd[k*IN_W +: IN_W] = bus.s_data;
            end else begin
                w_merged[k*IN_W +: IN_W] = PAD_VAL;
            end
        end
    end

    // Lane packing state
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            r_idx <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_idx <= '0;
                r_acc <= '0;
            end else begin
                r_idx <= r_idx + c_IDX_W'(1);
                r_acc <= w_acc_upd;
            end
        end
    end

    // Single-entry output register. A completing beat can only be accepted
    // while the held word is draining (wfull=0), so loading a new word here
    // never overwrites an unwritten one.
    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            r_out_vld <= 1'b0;
            r_wdata   <= '0;
        end else begin
            if (w_complete) begin
                r_out_vld <= 1'b1;
                r_wdata   <= w_merged;
            end else if (w_winc) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            r_wr_words <= '0;
        end else if (w_winc) begin
            r_wr_words <= r_wr_words + CNT_W'(1);
        end
    end

    assign bus.s_ready = w_ready;
    assign bus.winc    = w_winc;
    assign bus.wdata   = r_wdata;
    assign o_wr_words  = r_wr_words;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_packer
// Description : Self-checking bench for fifo_wr_packer. Two instances share
//               one stimulus: u_dut0 (PAD_VAL=0, 4-bit counter so the word
//               counter wraps) and u_dut2 (PAD_VAL=2'b10, 16-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_packer;

    logic        wclk = 1'b0;
    logic        wrstn;
    logic [3:0]  wr_words0;
    logic [15:0] wr_words2;

    always #5 wclk = ~wclk;

    fifo_wr_packer_if #(.WIDTH(8), .IN_W(2)) bus0 ();
    fifo_wr_packer_if #(.WIDTH(8), .IN_W(2)) bus2 ();

    assign bus2.s_valid = bus0.s_valid;
    assign bus2.s_data  = bus0.s_data;
    assign bus2.s_last  = bus0.s_last;
    assign bus2.wfull   = bus0.wfull;

    fifo_wr_packer #(.WIDTH(8), .IN_W(2), .PAD_VAL(2'b00), .CNT_W(4)) u_dut0 (
        .wclk       (wclk),
        .wrstn      (wrstn),
        .bus        (bus0),
        .o_wr_words (wr_words0)
    );

    fifo_wr_packer #(.WIDTH(8), .IN_W(2), .PAD_VAL(2'b10), .CNT_W(16)) u_dut2 (
        .wclk       (wclk),
        .wrstn      (wrstn),
        .bus        (bus2),
        .o_wr_words (wr_words2)
    );

    typedef struct packed {
        logic       v;
        logic [1:0] d;
        logic       l;
        logic       wf;
        logic       rdy;
        logic       winc;
        logic [7:0] wd;
        logic [7:0] wd2;
    } vec_t;

    vec_t tbl [26];

    int checks   = 0;
    int failures = 0;

    // Scoreboard state for the random phase
    logic [7:0] exp_q [$];
    logic [7:0] m_acc;
    int         m_pos;
    int         exp_cnt;
    int         beats;

    function automatic vec_t mk(input logic v, input logic [1:0] d, input logic l,
                                input logic wf, input logic rdy, input logic winc,
                                input logic [7:0] wd, input logic [7:0] wd2);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.wf = wf;
        r.rdy = rdy; r.winc = winc; r.wd = wd; r.wd2 = wd2;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic l, input logic wf);
        bus0.s_valid = v;
        bus0.s_data  = d;
        bus0.s_last  = l;
        bus0.wfull   = wf;
    endtask

    task automatic next_cycle();
        @(posedge wclk);
        #1;
    endtask

    // One random-phase cycle: apply inputs, score the write port, update model.
    task automatic rnd_cycle(input logic v, input logic [1:0] d, input logic l, input logic wf);
        logic       r, w;
        logic [7:0] wd, e;
        drive(v, d, l, wf);
        #3;
        r  = bus0.s_ready;
        w  = bus0.winc;
        wd = bus0.wdata;
        if (wf)  chk("rnd_winc_while_full", {31'd0, w}, 32'd0);
        if (!wf) chk("rnd_ready_not_full", {31'd0, r}, 32'd1);
        if (w) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rnd_extra_winc: got winc=1 wdata=%0h expected no write", wd);
            end else begin
                e = exp_q.pop_front();
                if (wd !== e) begin
                    failures++;
                    $display("FAIL rnd_wdata: got %0h expected %0h", wd, e);
                end
            end
            exp_cnt++;
        end
        if (v && r) begin
            m_acc[m_pos*2 +: 2] = d;
            beats++;
            if (m_pos == 3 || l) begin
                exp_q.push_back(m_acc);
                m_acc = 8'h00;
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        next_cycle();
        if (w) chk("rnd_wr_words", {28'd0, wr_words0}, {28'd0, exp_cnt[3:0]});
    endtask

    initial begin
        wrstn = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        @(posedge wclk);
        @(posedge wclk);
        #1;
        chk("rst_winc",     {31'd0, bus0.winc},    32'd0);
        chk("rst_ready",    {31'd0, bus0.s_ready}, 32'd1);
        chk("rst_wdata",    {24'd0, bus0.wdata},   32'd0);
        chk("rst_wr_words", {28'd0, wr_words0},    32'd0);
        wrstn = 1'b1;

        // ---------------- table: tests 1, 2, 3 ----------------
        tbl[0] = mk(1, 2'd1, 0, 0, 1, 0, 8'h00, 8'h00);
        tbl[1] = mk(1, 2'd2, 0, 0, 1, 0, 8'h00, 8'h00);
        tbl[2] = mk(1, 2'd3, 0, 0, 1, 0, 8'h00, 8'h00);
        tbl[3] = mk(1, 2'd0, 1, 0, 1, 0, 8'h00, 8'h00);
        tbl[4] = mk(0, 2'd0, 0, 0, 1, 1, 8'h39, 8'h39);
        tbl[5] = mk(1, 2'd3, 0, 0, 1, 0, 8'h39, 8'h39);
        tbl[6] = mk(1, 2'd1, 1, 0, 1, 0, 8'h39, 8'h39);
        tbl[7] = mk(0, 2'd0, 0, 0, 1, 1, 8'h07, 8'hA7);
        for (int i = 8; i < 24; i++) begin
            tbl[i] = mk(1, 2'd3, 0, 0, 1,
                        (i == 12 || i == 16 || i == 20) ? 1'b1 : 1'b0,
                        (i < 12) ? 8'h07 : 8'hFF,
                        (i < 12) ? 8'hA7 : 8'hFF);
        end
        tbl[24] = mk(0, 2'd0, 0, 0, 1, 1, 8'hFF, 8'hFF);
        tbl[25] = mk(0, 2'd0, 0, 0, 1, 0, 8'hFF, 8'hFF);

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].wf);
            #3;
            chk($sformatf("tbl%0d_ready", i), {31'd0, bus0.s_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_winc",  i), {31'd0, bus0.winc},    {31'd0, tbl[i].winc});
            chk($sformatf("tbl%0d_wdata", i), {24'd0, bus0.wdata},   {24'd0, tbl[i].wd});
            chk($sformatf("tbl%0d_wdata_pad", i), {24'd0, bus2.wdata}, {24'd0, tbl[i].wd2});
            next_cycle();
        end
        chk("tbl_wr_words",    {28'd0, wr_words0}, 32'd6);
        chk("tbl_wr_words_16", {16'd0, wr_words2}, 32'd6);

        // ---------------- test 4: wfull stall ----------------
        begin
            logic [1:0] bt [4];
            bt[0] = 2'd2; bt[1] = 2'd0; bt[2] = 2'd1; bt[3] = 2'd3;
            for (int i = 0; i < 4; i++) begin
                drive(1, bt[i], 0, 0);
                #3;
                chk("stall_fill_ready", {31'd0, bus0.s_ready}, 32'd1);
                next_cycle();
            end
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 2'd1, 0, 1);
            #3;
            chk("stall_winc",  {31'd0, bus0.winc},    32'd0);
            chk("stall_ready", {31'd0, bus0.s_ready}, 32'd0);
            chk("stall_wdata", {24'd0, bus0.wdata},   32'hD2);
            next_cycle();
        end
        drive(1, 2'd1, 0, 0);
        #3;
        chk("unstall_winc",  {31'd0, bus0.winc},    32'd1);
        chk("unstall_ready", {31'd0, bus0.s_ready}, 32'd1);
        chk("unstall_wdata", {24'd0, bus0.wdata},   32'hD2);
        next_cycle();
        drive(1, 2'd2, 1, 0);
        #3;
        chk("unstall_single_winc", {31'd0, bus0.winc},    32'd0);
        chk("unstall_ready_after", {31'd0, bus0.s_ready}, 32'd1);
        next_cycle();
        drive(0, 2'd0, 0, 0);
        #3;
        chk("post_stall_winc",  {31'd0, bus0.winc},  32'd1);
        chk("post_stall_wdata", {24'd0, bus0.wdata}, 32'h09);
        next_cycle();
        #3;
        chk("post_stall_idle",     {31'd0, bus0.winc}, 32'd0);
        chk("post_stall_wr_words", {28'd0, wr_words0}, 32'd8);
        next_cycle();

        // ---------------- test 5: reset mid-frame ----------------
        for (int i = 0; i < 2; i++) begin
            drive(1, 2'd3, 0, 0);
            next_cycle();
        end
        drive(0, 2'd0, 0, 0);
        #3;
        wrstn = 1'b0;
        #1;
        chk("arst_winc",     {31'd0, bus0.winc},    32'd0);
        chk("arst_ready",    {31'd0, bus0.s_ready}, 32'd1);
        chk("arst_wdata",    {24'd0, bus0.wdata},   32'd0);
        chk("arst_wr_words", {16'd0, wr_words2},    32'd0);
        next_cycle();
        wrstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("arst_no_winc", {31'd0, bus0.winc}, 32'd0);
            next_cycle();
        end
        drive(1, 2'd1, 0, 0);
        next_cycle();
        drive(1, 2'd3, 1, 0);
        next_cycle();
        drive(0, 2'd0, 0, 0);
        #3;
        chk("arst_new_winc",      {31'd0, bus0.winc},  32'd1);
        chk("arst_new_wdata",     {24'd0, bus0.wdata}, 32'h0D);
        chk("arst_new_wdata_pad", {24'd0, bus2.wdata}, 32'hAD);
        next_cycle();
        chk("arst_new_wr_words", {28'd0, wr_words0}, 32'd1);

        // ---------------- test 6: random with scoreboard ----------------
        m_acc   = 8'h00;
        m_pos   = 0;
        exp_cnt = 1;
        beats   = 0;
        for (int cyc = 0; cyc < 20000 && beats < 1000; cyc++) begin
            rnd_cycle(($urandom % 4) != 0, 2'($urandom % 4),
                      ($urandom % 5) == 0, ($urandom % 3) == 0);
        end
        chk("rnd_beats", beats, 32'd1000);
        for (int i = 0; i < 8; i++) rnd_cycle(1'b0, 2'd0, 1'b0, 1'b0);
        chk("rnd_drained",     exp_q.size(), 32'd0);
        chk("rnd_wr_words_16", {16'd0, wr_words2}, {16'd0, exp_cnt[15:0]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
